// File: rtl/regfile_wb_arbiter_if.sv
// Multiply/divide result handshake into the writeback arbiter.
// master: MDU side drives valid/Rd/data; slave: arbiter drives ready.
interface regfile_wb_arbiter_if #(
    parameter int XLEN = 32
);
    logic            mdu_valid_i;
    logic            mdu_ready_o;
    logic [4:0]      mdu_Rd_i;
    logic [XLEN-1:0] mdu_data_i;

    modport master (
        output mdu_valid_i,
        output mdu_Rd_i,
        output mdu_data_i,
        input  mdu_ready_o
    );

    modport slave (
        input  mdu_valid_i,
        input  mdu_Rd_i,
        input  mdu_data_i,
        output mdu_ready_o
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between the pipeline writeback (A,
// never stalled) and the MDU (B, valid/ready into a DEPTH-entry FIFO).
// Ports: clk, rst (sync, active-high); wbA_* pipeline writeback;
//   mdu (slave modport) MDU result handshake; Rd_o/RegWrite_o/Wr_data_o
//   register file write port; chk_* decode registers -> pending_hit_o;
//   stall_o one-cycle bubble request; fifo_count_o FIFO occupancy.
// Optional macro STARVE_GUARD_EN builds the starvation counter/stall_o;
//   without it stall_o is tied 0 and B drains only on A-idle cycles.
module regfile_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wbA_valid_i,
    input  logic [4:0]               wbA_Rd_i,
    input  logic [XLEN-1:0]          wbA_data_i,
    regfile_wb_arbiter_if.slave      mdu,
    output logic [4:0]               Rd_o,
    output logic                     RegWrite_o,
    output logic [XLEN-1:0]          Wr_data_o,
    input  logic [4:0]               chk_Rs1_i,
    input  logic [4:0]               chk_Rs2_i,
    input  logic [4:0]               chk_Rd_i,
    output logic                     pending_hit_o,
    output logic                     stall_o,
    output logic [$clog2(DEPTH):0]   fifo_count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 2)
    begin : g_param_err
        $error("regfile_wb_arbiter: illegal DEPTH or STARVE_LIMIT");
    end

    logic [4:0]      mem_rd_q   [DEPTH];
    logic [4:0]      mem_rd_d   [DEPTH];
    logic [XLEN-1:0] mem_data_q [DEPTH];
    logic [XLEN-1:0] mem_data_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic empty;
    logic full;
    logic a_active;
    logic pop;
    logic push;
    logic store;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // Ready depends on registered occupancy only: no comb path from A.
    assign mdu.mdu_ready_o = !full;

    // A is gated during reset so nothing reaches the register file.
    assign a_active = !rst && wbA_valid_i && (wbA_Rd_i != 5'd0);
    assign pop      = !rst && !a_active && !empty;
    assign push     = !rst && mdu.mdu_valid_i && !full;
    // Rd=0 results are acknowledged but never need a write.
    assign store    = push && (mdu.mdu_Rd_i != 5'd0);

    assign fifo_count_o = count_q;

    always_comb begin
        RegWrite_o = 1'b0;
        Rd_o       = 5'd0;
        Wr_data_o  = '0;
        if (a_active) begin
            RegWrite_o = 1'b1;
            Rd_o       = wbA_Rd_i;
            Wr_data_o  = wbA_data_i;
        end else if (pop) begin
            RegWrite_o = 1'b1;
            Rd_o       = mem_rd_q[rd_ptr_q];
            Wr_data_o  = mem_data_q[rd_ptr_q];
        end
    end

    always_comb begin
        mem_rd_d   = mem_rd_q;
        mem_data_d = mem_data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (store) begin
            mem_rd_d[wr_ptr_q]   = mdu.mdu_Rd_i;
            mem_data_d[wr_ptr_q] = mdu.mdu_data_i;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // store implies !full and pop implies !empty, so no wrap.
        count_d = count_q + CW'(store) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides validity.
    always_ff @(posedge clk) begin
        mem_rd_q   <= mem_rd_d;
        mem_data_q <= mem_data_d;
    end

    function automatic logic chk_match(
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic [4:0] rdc
    );
        return (rd != 5'd0) && (rd == rs1 || rd == rs2 || rd == rdc);
    endfunction

    always_comb begin
        pending_hit_o = push &&
            chk_match(mdu.mdu_Rd_i, chk_Rs1_i, chk_Rs2_i, chk_Rd_i);
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q &&
                chk_match(mem_rd_q[rd_ptr_q + AW'(i)],
                          chk_Rs1_i, chk_Rs2_i, chk_Rd_i)) begin
                pending_hit_o = 1'b1;
            end
        end
    end

`ifdef STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT) + 1;

    logic [SW-1:0] starve_q, starve_d;
    logic          stall_q, stall_d;

    // Counts cycles where the head is waiting behind an active A.
    always_comb begin
        starve_d = starve_q;
        stall_d  = 1'b0;
        if (pop || empty) begin
            starve_d = '0;
        end else if (a_active) begin
            if (starve_q == SW'(STARVE_LIMIT - 1)) begin
                starve_d = '0;
                stall_d  = 1'b1;
            end else begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    assign stall_o = stall_q;
`else
    assign stall_o = 1'b0;
`endif
endmodule
